// File: rtl/cache_fill_responder_pkg.sv
// Shared types and defaults for the cache fill responder: owner states,
// default fill geometry and the byte-to-word address shift.
package cache_fill_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } owner_t;

  localparam int LATENCY_DEF         = 4;
  localparam int WORDS_PER_BLOCK_DEF = 8;
  localparam int DATA_W              = 16;
  // Word index is the byte address with bit 0 dropped.
  localparam int WORD_LSB            = 1;

endpackage

// File: rtl/cache_fill_responder_if.sv
// Bus between the two cache fill FSMs (master side) and the fill responder
// (slave side).
interface cache_fill_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              memory_data_valid;
  logic              i_grant;
  logic              d_grant;
  logic              waitForICACHE;
  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  mem_rdata, memory_data_valid, i_grant, d_grant, waitForICACHE, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output mem_rdata, memory_data_valid, i_grant, d_grant, waitForICACHE, busy
  );
endinterface

// File: rtl/cache_fill_responder_mem_latency_pipe.sv
// LATENCY-deep {valid, data} shift register carrying read words to the
// return port; pending flags words still ahead of the output stage.
module cache_fill_responder_mem_latency_pipe #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out,
  output logic              pending
);

  logic              vld_p  [LATENCY];
  logic [DATA_W-1:0] data_p [LATENCY];

  // Stage 0 captures the word read this cycle; later stages just shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= vld_in;
      data_p[0] <= vld_in ? data_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[LATENCY-1];
  assign data_out = data_p[LATENCY-1];

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      pending = pending | vld_p[i];
    end
  end

endmodule

// File: rtl/cache_fill_responder.sv
// Arbitrates I-cache and D-cache fills and D-cache single-word writes onto
// an internal word store, returning fill words through a fixed-latency pipe.
module cache_fill_responder
  import cache_fill_responder_pkg::*;
#(
  parameter int LATENCY         = LATENCY_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int ADDR_W          = 16,
  parameter int MEM_WORDS       = 32768
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_fill_responder_if.slave  bus
);

  localparam int CNT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

  owner_t            state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue_stop;
  logic              fill, owner_req, accept, fill_done;
  logic [ADDR_W-1:0] owner_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rd_word;
  logic              pipe_vld, pipe_pending;
  logic [DATA_W-1:0] pipe_data;
  logic              i_grant, d_grant, busy, wait_i;

  assign fill       = (state == I_FILL) || (state == D_FILL);
  assign owner_req  = (state == I_FILL) ? bus.i_req  : bus.d_req;
  assign owner_addr = (state == I_FILL) ? bus.i_addr : bus.d_addr;
  // Truncation to IDX_W bits gives the modulo-MEM_WORDS wrap.
  assign word_idx   = IDX_W'(owner_addr >> WORD_LSB);

  // Once the block is fully issued or the requester lets go, issue stops for
  // good; the fill ends when nothing remains ahead of the output stage.
  assign accept    = fill && owner_req && !issue_stop;
  assign fill_done = fill && (issue_stop || !owner_req) && !pipe_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.i_req)                    state_nxt = I_FILL;
        else if (bus.d_req && !bus.d_wr)  state_nxt = D_FILL;
        else if (bus.d_req &&  bus.d_wr)  state_nxt = D_WRITE;
      end
      I_FILL, D_FILL: if (fill_done) state_nxt = IDLE;
      D_WRITE:        state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_grant = (state == I_FILL);
    d_grant = (state == D_FILL) || (state == D_WRITE);
    busy    = (state != IDLE);
    wait_i  = (state == I_FILL) || ((state == IDLE) && bus.i_req && bus.d_req);
  end

  always_ff @(posedge clk) begin
    if (rst || !fill) begin
      issue_cnt  <= '0;
      issue_stop <= 1'b0;
    end else begin
      if (accept) begin
        issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
      end
      if ((accept && (issue_cnt == LAST_IDX)) || !owner_req) begin
        issue_stop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == D_WRITE) begin
      mem[word_idx] <= bus.d_wdata;
    end
  end

  assign rd_word = mem[word_idx];

  cache_fill_responder_mem_latency_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (accept),
    .data_in  (rd_word),
    .vld_out  (pipe_vld),
    .data_out (pipe_data),
    .pending  (pipe_pending)
  );

  assign bus.mem_rdata         = pipe_data;
  assign bus.memory_data_valid = pipe_vld;
  assign bus.i_grant           = i_grant;
  assign bus.d_grant           = d_grant;
  assign bus.busy              = busy;
  assign bus.waitForICACHE     = wait_i;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed and randomized bench for cache_fill_responder against a word-store
// model indexed by byte address / 2 modulo the store depth.
module tb_cache_fill_responder;

  localparam int L    = 4;
  localparam int WPB  = 8;
  localparam int MEMW = 32768;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_responder_if bus ();

  cache_fill_responder #(
    .LATENCY         (L),
    .WORDS_PER_BLOCK (WPB),
    .ADDR_W          (16),
    .MEM_WORDS       (MEMW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] model [int];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [15:0] addr, input int k);
    return (((int'(addr) + 2 * k) % 65536) / 2) % MEMW;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] base, input int k);
    int idx;
    idx = word_of(base, k);
    if (model.exists(idx)) return model[idx];
    return 16'hxxxx;
  endfunction

  task automatic drive(input bit is_i, input bit req, input logic [15:0] a,
                       input bit d_hold, input logic [15:0] dbase);
    bus.d_wr = 1'b0;
    if (is_i) begin
      bus.i_req  = req;
      bus.i_addr = a;
      bus.d_req  = d_hold;
      bus.d_addr = dbase;
    end else begin
      bus.i_req  = 1'b0;
      bus.d_req  = req;
      bus.d_addr = a;
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = addr;
    bus.d_wdata = data;
    tick();
    chk1("wr_grant", bus.d_grant, 1'b1);
    chk1("wr_no_valid", bus.memory_data_valid, 1'b0);
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    tick();
    chk1("wr_idle_busy", bus.busy, 1'b0);
    chk1("wr_idle_valid", bus.memory_data_valid, 1'b0);
    model[word_of(addr, 0)] = data;
  endtask

  // Requester presents base+2c in the c-th owned cycle while c < hold; the
  // word accepted in owned cycle c must come back in owned cycle c+L.
  task automatic do_fill(input bit is_i, input logic [15:0] base, input int hold,
                         input bit d_hold, input logic [15:0] dbase);
    logic [15:0] a;
    logic        exp_v;
    drive(is_i, 1'b1, base, d_hold, dbase);
    #1;
    chk1("req_busy", bus.busy, 1'b0);
    chk1("req_wait", bus.waitForICACHE, is_i && d_hold);
    tick();
    for (int c = 0; c < hold + L; c++) begin
      a = base + 16'(2 * c);
      drive(is_i, c < hold, a, d_hold, dbase);
      #1;
      chk1(is_i ? "i_grant" : "d_grant", is_i ? bus.i_grant : bus.d_grant, 1'b1);
      chk1("other_grant", is_i ? bus.d_grant : bus.i_grant, 1'b0);
      chk1("fill_wait", bus.waitForICACHE, is_i);
      exp_v = (c >= L);
      chk1("fill_valid", bus.memory_data_valid, exp_v);
      if (exp_v) chk16("fill_data", bus.mem_rdata, model_word(base, c - L));
      tick();
    end
    drive(is_i, 1'b0, base, d_hold, dbase);
    #1;
    chk1("end_busy", bus.busy, 1'b0);
    chk1("end_grant", is_i ? bus.i_grant : bus.d_grant, 1'b0);
    chk1("end_valid", bus.memory_data_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          side;
    int          w;
    int          hold;
    logic [15:0] addr;

    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    tick();
    tick();
    chk16("rst_rdata", bus.mem_rdata, 16'h0000);
    chk1("rst_valid", bus.memory_data_valid, 1'b0);
    chk1("rst_i_grant", bus.i_grant, 1'b0);
    chk1("rst_d_grant", bus.d_grant, 1'b0);
    chk1("rst_wait", bus.waitForICACHE, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // Preload: block at words 0x20..0x27, wrap words, random region 0x80..0xBF.
    for (int k = 0; k < 8; k++) do_write(16'(16'h0040 + 2 * k), 16'(16'hA020 + k));
    for (int k = 0; k < 7; k++) do_write(16'(2 * k), 16'(16'hA000 + k));
    do_write(16'hFFFE, 16'h5A5A);
    for (int k = 16'h80; k < 16'hC0; k++) do_write(16'(2 * k), 16'($urandom));

    do_fill(1'b1, 16'h0040, 8, 1'b0, 16'h0000);

    // Both request together: I first, D waits and starts right after IDLE.
    do_fill(1'b1, 16'h0040, 8, 1'b1, 16'h0180);
    do_fill(1'b0, 16'h0180, 8, 1'b0, 16'h0000);

    do_write(16'h0100, 16'hBEEF);
    do_fill(1'b0, 16'h0100, 8, 1'b0, 16'h0000);

    // Reset after three accepted words: nothing may come back.
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    tick();
    for (int c = 0; c < 3; c++) begin
      bus.i_addr = 16'(16'h0040 + 2 * c);
      #1;
      chk1("mid_i_grant", bus.i_grant, 1'b1);
      tick();
    end
    rst       = 1'b1;
    bus.i_req = 1'b0;
    tick();
    chk16("mrst_rdata", bus.mem_rdata, 16'h0000);
    chk1("mrst_valid", bus.memory_data_valid, 1'b0);
    chk1("mrst_i_grant", bus.i_grant, 1'b0);
    chk1("mrst_d_grant", bus.d_grant, 1'b0);
    chk1("mrst_wait", bus.waitForICACHE, 1'b0);
    chk1("mrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk1("post_rst_valid", bus.memory_data_valid, 1'b0);
      chk1("post_rst_busy", bus.busy, 1'b0);
    end
    do_fill(1'b1, 16'h0040, 8, 1'b0, 16'h0000);

    do_fill(1'b1, 16'h0040, 5, 1'b0, 16'h0000);
    tick();
    chk1("drop_quiet", bus.memory_data_valid, 1'b0);

    do_fill(1'b1, 16'hFFFE, 8, 1'b0, 16'h0000);

    for (int n = 0; n < 14; n++) begin
      side = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(16'h80, 16'hB8));
      addr = 16'(2 * w + int'($urandom_range(0, 1)));
      hold = int'($urandom_range(1, WPB));
      if ($urandom_range(0, 2) == 0) begin
        do_write(16'(2 * int'($urandom_range(16'h80, 16'hBF)) + int'($urandom_range(0, 1))),
                 16'($urandom));
      end
      do_fill(side, addr, hold, 1'b0, 16'h0000);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
